// File: rtl/aud_ctrl_pkg.sv
// Shared types for the record/playback controller: state encoding, command
// pulse bundle and the slot base-address helper.
package aud_ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT_REQ   = 3'd0,
    S_INIT_WAIT  = 3'd1,
    S_IDLE       = 3'd2,
    S_RECD       = 3'd3,
    S_RECD_PAUSE = 3'd4,
    S_PLAY       = 3'd5,
    S_PLAY_PAUSE = 3'd6
  } state_e;

  typedef struct packed {
    logic init_start;
    logic rec_start;
    logic rec_pause;
    logic play_start;
    logic play_pause;
    logic stop;
  } cmd_t;

  // Slots are equal power-of-two regions, so k*R reduces to a constant shift.
  function automatic logic [63:0] slot_base(input logic [31:0] k, input int addr_w,
                                            input int n_slots);
    return 64'(k) << (addr_w - $clog2(n_slots));
  endfunction

endpackage

// File: rtl/aud_sec_counter.sv
// Elapsed-seconds counter: divides the clock by TICKS_PER_SEC while i_run is
// high, holds otherwise, saturates at the top of SEC_W; i_clr has priority.
module aud_sec_counter #(
  parameter int TICKS_PER_SEC = 12000000,
  parameter int SEC_W         = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic             i_clr,
  output logic [SEC_W-1:0] o_sec
);

  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0]  SEC_MAX   = '1;

  logic [TICK_W-1:0] r_tick;
  logic [SEC_W-1:0]  r_sec;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick <= '0;
      r_sec  <= '0;
    end else if (i_clr) begin
      r_tick <= '0;
      r_sec  <= '0;
    end else if (i_run) begin
      if (r_tick == TICK_LAST) begin
        r_tick <= '0;
        if (r_sec != SEC_MAX) r_sec <= r_sec + 1'b1;
      end else begin
        r_tick <= r_tick + 1'b1;
      end
    end
  end

  assign o_sec = r_sec;

endmodule

// File: rtl/aud_rec_ctrl.sv
// Record/playback controller over N_SLOTS SRAM regions with codec init sequencing.
// Optional: define AUD_CTRL_LOOP_EN to make end-of-slot restart playback in place.
module aud_rec_ctrl
  import aud_ctrl_pkg::*;
#(
  parameter int ADDR_W        = 20,
  parameter int N_SLOTS       = 4,
  parameter int TICKS_PER_SEC = 12000000,
  parameter int SEC_W         = 6,
  localparam int SLOT_W       = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_key_stop,
  input  logic                i_key_play,
  input  logic                i_key_recd,
  input  logic [SLOT_W-1:0]   i_slot,
  input  logic                i_init_done,
  input  logic [ADDR_W-1:0]   i_rec_addr,
  input  logic [ADDR_W-1:0]   i_play_addr,
  output logic                o_init_start,
  output logic                o_rec_start,
  output logic                o_rec_pause,
  output logic                o_play_start,
  output logic                o_play_pause,
  output logic                o_stop,
  output logic [ADDR_W-1:0]   o_base_addr,
  output logic [ADDR_W-1:0]   o_end_addr,
  output logic                o_sram_we,
  output logic [2:0]          o_state,
  output logic [N_SLOTS-1:0]  o_slot_valid,
  output logic [SEC_W-1:0]    o_rec_sec,
  output logic [SEC_W-1:0]    o_play_sec
);

  // Last offset inside a region; R-1 always fits in ADDR_W even with one slot.
  localparam logic [ADDR_W-1:0] REGION_LAST =
    ADDR_W'((64'd1 << (ADDR_W - $clog2(N_SLOTS))) - 64'd1);

  state_e              r_state, w_state_nx;
  cmd_t                r_cmd, w_cmd_nx;
  logic [ADDR_W-1:0]   r_base, w_base_nx;
  logic [ADDR_W-1:0]   r_end, w_end_nx;
  logic [SLOT_W-1:0]   r_slot, w_slot_nx;
  logic                r_sram_we;
  logic [N_SLOTS-1:0]  r_slot_valid;
  logic [ADDR_W-1:0]   r_len [N_SLOTS];

  logic [SLOT_W-1:0]   w_sel;
  logic [ADDR_W-1:0]   w_sel_base;
  logic                w_valid_set, w_valid_clr, w_len_we, w_rec_stop, w_sec_clr;
  logic                w_sec_run;
  logic [SEC_W-1:0]    w_sec;

  assign w_sel      = (N_SLOTS > 1) ? i_slot : '0;
  assign w_sel_base = ADDR_W'(slot_base(32'(w_sel), ADDR_W, N_SLOTS));

  always_comb begin
    w_state_nx  = r_state;
    w_cmd_nx    = '0;
    w_base_nx   = r_base;
    w_end_nx    = r_end;
    w_slot_nx   = r_slot;
    w_valid_set = 1'b0;
    w_valid_clr = 1'b0;
    w_len_we    = 1'b0;
    w_rec_stop  = 1'b0;
    w_sec_clr   = 1'b0;
    unique case (r_state)
      S_INIT_REQ: begin
        w_cmd_nx.init_start = 1'b1;
        w_state_nx          = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (i_init_done) w_state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (i_key_recd) begin
          w_slot_nx          = w_sel;
          w_valid_clr        = 1'b1;
          w_base_nx          = w_sel_base;
          w_end_nx           = w_sel_base + REGION_LAST;
          w_cmd_nx.rec_start = 1'b1;
          w_sec_clr          = 1'b1;
          w_state_nx         = S_RECD;
        end else if (i_key_play && r_slot_valid[w_sel]) begin
          w_slot_nx           = w_sel;
          w_base_nx           = w_sel_base;
          w_end_nx            = r_len[w_sel];
          w_cmd_nx.play_start = 1'b1;
          w_sec_clr           = 1'b1;
          w_state_nx          = S_PLAY;
        end
      end
      S_RECD: begin
        if (i_key_stop || (i_rec_addr >= r_end)) begin
          w_rec_stop = 1'b1;
        end else if (i_key_recd) begin
          w_cmd_nx.rec_pause = 1'b1;
          w_state_nx         = S_RECD_PAUSE;
        end
      end
      S_RECD_PAUSE: begin
        if (i_key_stop) begin
          w_rec_stop = 1'b1;
        end else if (i_key_recd) begin
          w_cmd_nx.rec_start = 1'b1;
          w_state_nx         = S_RECD;
        end
      end
      S_PLAY: begin
        if (i_key_stop) begin
          w_cmd_nx.stop = 1'b1;
          w_state_nx    = S_IDLE;
        end else if (i_play_addr > r_end) begin
`ifdef AUD_CTRL_LOOP_EN
          w_cmd_nx.stop       = 1'b1;
          w_cmd_nx.play_start = 1'b1;
          w_sec_clr           = 1'b1;
`else
          w_cmd_nx.stop = 1'b1;
          w_state_nx    = S_IDLE;
`endif
        end else if (i_key_play) begin
          w_cmd_nx.play_pause = 1'b1;
          w_state_nx          = S_PLAY_PAUSE;
        end
      end
      S_PLAY_PAUSE: begin
        if (i_key_stop) begin
          w_cmd_nx.stop = 1'b1;
          w_state_nx    = S_IDLE;
        end else if (i_key_play) begin
          w_cmd_nx.play_start = 1'b1;
          w_state_nx          = S_PLAY;
        end
      end
      default: w_state_nx = S_INIT_REQ;
    endcase
    // A finished take keeps its length; an empty take leaves the slot invalid.
    if (w_rec_stop) begin
      w_len_we      = 1'b1;
      w_valid_set   = (i_rec_addr != r_base);
      w_cmd_nx.stop = 1'b1;
      w_state_nx    = S_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_INIT_REQ;
      r_cmd        <= '0;
      r_base       <= '0;
      r_end        <= '0;
      r_slot       <= '0;
      r_sram_we    <= 1'b0;
      r_slot_valid <= '0;
      for (int k = 0; k < N_SLOTS; k++) r_len[k] <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cmd     <= w_cmd_nx;
      r_base    <= w_base_nx;
      r_end     <= w_end_nx;
      r_slot    <= w_slot_nx;
      r_sram_we <= (w_state_nx == S_RECD);
      if (w_valid_clr) r_slot_valid[w_sel]  <= 1'b0;
      if (w_valid_set) r_slot_valid[r_slot] <= 1'b1;
      if (w_len_we)    r_len[r_slot]        <= i_rec_addr;
    end
  end

  assign w_sec_run = (r_state == S_RECD) || (r_state == S_PLAY);

  aud_sec_counter #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .SEC_W         (SEC_W)
  ) u_sec (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_run   (w_sec_run),
    .i_clr   (w_sec_clr),
    .o_sec   (w_sec)
  );

  assign o_init_start = r_cmd.init_start;
  assign o_rec_start  = r_cmd.rec_start;
  assign o_rec_pause  = r_cmd.rec_pause;
  assign o_play_start = r_cmd.play_start;
  assign o_play_pause = r_cmd.play_pause;
  assign o_stop       = r_cmd.stop;
  assign o_base_addr  = r_base;
  assign o_end_addr   = r_end;
  assign o_sram_we    = r_sram_we;
  assign o_state      = r_state;
  assign o_slot_valid = r_slot_valid;
  assign o_rec_sec    = ((r_state == S_RECD) || (r_state == S_RECD_PAUSE)) ? w_sec : '0;
  assign o_play_sec   = ((r_state == S_PLAY) || (r_state == S_PLAY_PAUSE)) ? w_sec : '0;

endmodule
